// File: rtl/vc_arbiter_ctrl.sv
// Transmit-side virtual-channel controller: sequences VC FIFO bring-up, then
// moves words from VC0/VC1 into destinations D0/D1 with strict VC0 priority.
module vc_arbiter_ctrl #(
    parameter int data_width   = 6,
    parameter int umbral_width = 4,
    parameter int cnt_width    = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    init_i,
    input  logic [umbral_width-1:0] umbral_vc0_in_i,
    input  logic [umbral_width-1:0] umbral_vc1_in_i,
    output logic [umbral_width-1:0] umbral_vc0_o,
    output logic [umbral_width-1:0] umbral_vc1_o,
    output logic                    fifo_init_o,
    input  logic                    empty_vc0_i,
    input  logic                    empty_vc1_i,
    input  logic [data_width-1:0]   data_vc0_i,
    input  logic [data_width-1:0]   data_vc1_i,
    input  logic                    almost_full_d0_i,
    input  logic                    almost_full_d1_i,
    input  logic                    error_vc0_i,
    input  logic                    error_vc1_i,
    input  logic                    error_d0_i,
    input  logic                    error_d1_i,
    output logic                    rd_vc0_o,
    output logic                    rd_vc1_o,
    output logic                    push_d0_o,
    output logic                    push_d1_o,
    output logic [data_width-1:0]   data_out_o,
    output logic [cnt_width-1:0]    cnt_d0_o,
    output logic [cnt_width-1:0]    cnt_d1_o,
    output logic [4:0]              state_o,
    output logic                    idle_o,
    output logic                    error_out_o
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

    state_e                  state_q, state_d;
    logic [umbral_width-1:0] umbral_vc0_q, umbral_vc0_d;
    logic [umbral_width-1:0] umbral_vc1_q, umbral_vc1_d;
    logic                    push_d0_q, push_d0_d;
    logic                    push_d1_q, push_d1_d;
    logic [data_width-1:0]   data_out_q, data_out_d;
    logic [cnt_width-1:0]    cnt_d0_q, cnt_d0_d;
    logic [cnt_width-1:0]    cnt_d1_q, cnt_d1_d;

    logic                    any_error;
    logic                    arb_en;
    logic                    blk0, blk1;
    logic                    grant0, grant1, grant_any;
    logic [data_width-1:0]   grant_word;

    // Error and init pre-empt arbitration, so a word is only read when it
    // is guaranteed to be pushed on the next edge.
    always_comb begin
        any_error  = error_vc0_i | error_vc1_i | error_d0_i | error_d1_i;
        arb_en     = (state_q == ST_ACTIVE) && !reset_i && !any_error && !init_i;
        blk0       = data_vc0_i[data_width-1] ? almost_full_d1_i : almost_full_d0_i;
        blk1       = data_vc1_i[data_width-1] ? almost_full_d1_i : almost_full_d0_i;
        grant0     = arb_en && !empty_vc0_i && !blk0;
        grant1     = arb_en && !grant0 && !empty_vc1_i && !blk1;
        grant_any  = grant0 | grant1;
        grant_word = grant0 ? data_vc0_i : data_vc1_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT: begin
                if (any_error)    state_d = ST_ERROR;
                else if (!init_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_error)                        state_d = ST_ERROR;
                else if (init_i)                      state_d = ST_INIT;
                else if (!empty_vc0_i || !empty_vc1_i) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_error)                       state_d = ST_ERROR;
                else if (init_i)                     state_d = ST_INIT;
                else if (empty_vc0_i && empty_vc1_i) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        umbral_vc0_d = umbral_vc0_q;
        umbral_vc1_d = umbral_vc1_q;
        push_d0_d    = grant_any && !grant_word[data_width-1];
        push_d1_d    = grant_any &&  grant_word[data_width-1];
        data_out_d   = data_out_q;
        cnt_d0_d     = cnt_d0_q;
        cnt_d1_d     = cnt_d1_q;
        if (state_q == ST_INIT) begin
            umbral_vc0_d = umbral_vc0_in_i;
            umbral_vc1_d = umbral_vc1_in_i;
        end
        if (grant_any) data_out_d = grant_word;
        if (push_d0_d) cnt_d0_d = cnt_d0_q + cnt_width'(1);
        if (push_d1_d) cnt_d1_d = cnt_d1_q + cnt_width'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_RESET;
            umbral_vc0_q <= '0;
            umbral_vc1_q <= '0;
            push_d0_q    <= 1'b0;
            push_d1_q    <= 1'b0;
            data_out_q   <= '0;
            cnt_d0_q     <= '0;
            cnt_d1_q     <= '0;
        end else begin
            state_q      <= state_d;
            umbral_vc0_q <= umbral_vc0_d;
            umbral_vc1_q <= umbral_vc1_d;
            push_d0_q    <= push_d0_d;
            push_d1_q    <= push_d1_d;
            data_out_q   <= data_out_d;
            cnt_d0_q     <= cnt_d0_d;
            cnt_d1_q     <= cnt_d1_d;
        end
    end

    // FIFOs stay enabled in ERROR so their contents survive for inspection.
    assign fifo_init_o  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);
    assign umbral_vc0_o = umbral_vc0_q;
    assign umbral_vc1_o = umbral_vc1_q;
    assign rd_vc0_o     = grant0;
    assign rd_vc1_o     = grant1;
    assign push_d0_o    = push_d0_q;
    assign push_d1_o    = push_d1_q;
    assign data_out_o   = data_out_q;
    assign cnt_d0_o     = cnt_d0_q;
    assign cnt_d1_o     = cnt_d1_q;
    assign state_o      = state_q;
    assign idle_o       = (state_q == ST_IDLE);
    assign error_out_o  = (state_q == ST_ERROR);

endmodule
